// File: rtl/macarray_pkg.sv
// Shared constants and feeder state encoding for the 4x4 systolic MAC array front end.
package macarray_pkg;
    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int L_4X4 = 7;
    localparam int L_3X3 = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_COMMIT = 3'd4,
        S_DONE   = 3'd5
    } feeder_state_e;
endpackage

// File: rtl/macarray_skew_sel.sv
// Per-lane skew select: lane l at step t carries element t-l of its row/column, or zero outside [0,K).
module macarray_skew_sel
    import macarray_pkg::*;
(
    input  logic [1:0]        lane,
    input  logic [3:0]        step,
    input  logic [2:0]        k,
    input  logic [N*DW-1:0]   vec,
    output logic [DW-1:0]     operand
);

    logic [3:0] idx_s;

    // Select the diagonally delayed element for this lane
    always_comb begin
        idx_s   = step - {2'b00, lane};
        operand = 4'd0;
        if ((step >= {2'b00, lane}) && (idx_s < {1'b0, k})) begin
            operand = vec[idx_s[1:0]*DW +: DW];
        end else begin
            operand = 4'd0;
        end
    end

endmodule

// File: rtl/macarray_feeder.sv
// Operand sequencer for the 4x4 systolic MAC array: captures one A/B job, streams skewed
// operands, and sequences clr / enable / update_ready / done around the feed.
module macarray_feeder
    import macarray_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic         mode_3x3,
    input  logic [63:0]  a_mat,
    input  logic [63:0]  b_mat,
    input  logic         abort,
    output logic [3:0]   a_row0,
    output logic [3:0]   a_row1,
    output logic [3:0]   a_row2,
    output logic [3:0]   a_row3,
    output logic [3:0]   b_col0,
    output logic [3:0]   b_col1,
    output logic [3:0]   b_col2,
    output logic [3:0]   b_col3,
    output logic         clr,
    output logic [1:0]   enable,
    output logic         update_ready,
    output logic         busy,
    output logic         done
);

    feeder_state_e state_q, state_d, nxt_state_s;
    logic [3:0]    step_q, step_d;
    logic          mode_q, mode_d;
    logic [63:0]   a_q, a_d, b_q, b_d;

    logic [N-1:0][DW-1:0] a_row_q, a_row_d, b_col_q, b_col_d;
    logic [N-1:0][DW-1:0] a_sel_s, b_sel_s;
    logic                 clr_q, clr_d;
    logic [1:0]           enable_q, enable_d;
    logic                 update_ready_q, update_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_ready_q, start_ready_d;

    logic       accept_s;
    logic [3:0] last_feed_s;
    logic [2:0] k_s;

    assign accept_s    = start_valid & start_ready_q;
    assign last_feed_s = mode_q ? 4'(L_3X3 - 1) : 4'(L_4X4 - 1);
    assign k_s         = mode_d ? 3'd3 : 3'd4;

    // Next-state, step counter and operand capture
    always_comb begin
        nxt_state_s = state_q;
        step_d      = step_q;
        mode_d      = mode_q;
        a_d         = a_q;
        b_d         = b_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    nxt_state_s = S_CLEAR;
                    mode_d      = mode_3x3;
                    a_d         = a_mat;
                    b_d         = b_mat;
                end else begin
                    nxt_state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                nxt_state_s = S_FEED;
                step_d      = 4'd0;
            end
            S_FEED: begin
                if (step_q == last_feed_s) begin
                    nxt_state_s = S_DRAIN;
                    step_d      = 4'd0;
                end else begin
                    step_d      = step_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (step_q == 4'(DRAIN_CYCLES - 1)) begin
                    nxt_state_s = S_COMMIT;
                    step_d      = 4'd0;
                end else begin
                    step_d      = step_q + 4'd1;
                end
            end
            S_COMMIT: nxt_state_s = S_DONE;
            S_DONE:   nxt_state_s = S_IDLE;
            default:  nxt_state_s = S_IDLE;
        endcase
        state_d = (abort && (state_q != S_IDLE)) ? S_IDLE : nxt_state_s;
    end

    // Streams are driven from the next step so they line up with the registered state
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [N*DW-1:0] b_vec_s;
        for (genvar k = 0; k < N; k++) begin : g_col
            assign b_vec_s[k*DW +: DW] = b_d[(N*k + i)*DW +: DW];
        end
        macarray_skew_sel u_a_sel (
            .lane    (2'(i)),
            .step    (step_d),
            .k       (k_s),
            .vec     (a_d[i*N*DW +: N*DW]),
            .operand (a_sel_s[i])
        );
        macarray_skew_sel u_b_sel (
            .lane    (2'(i)),
            .step    (step_d),
            .k       (k_s),
            .vec     (b_vec_s),
            .operand (b_sel_s[i])
        );
    end

    // Output decode from the upcoming state
    always_comb begin
        clr_d          = (state_d == S_CLEAR);
        update_ready_d = (state_d == S_COMMIT);
        done_d         = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
        start_ready_d  = (state_d == S_IDLE);
        enable_d       = 2'b00;
        a_row_d        = 16'd0;
        b_col_d        = 16'd0;
        if ((state_d == S_CLEAR) || (state_d == S_FEED) ||
            (state_d == S_DRAIN) || (state_d == S_COMMIT)) begin
            enable_d = mode_d ? 2'b01 : 2'b11;
        end else begin
            enable_d = 2'b00;
        end
        for (int i = 0; i < N; i++) begin
            if ((state_d == S_FEED) && !(mode_d && (i == N - 1))) begin
                a_row_d[i] = a_sel_s[i];
                b_col_d[i] = b_sel_s[i];
            end else begin
                a_row_d[i] = 4'd0;
                b_col_d[i] = 4'd0;
            end
        end
    end

    // State, operand and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q        <= S_IDLE;
            step_q         <= 4'd0;
            mode_q         <= 1'b0;
            a_q            <= 64'd0;
            b_q            <= 64'd0;
            a_row_q        <= 16'd0;
            b_col_q        <= 16'd0;
            clr_q          <= 1'b0;
            enable_q       <= 2'b00;
            update_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            start_ready_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            mode_q         <= mode_d;
            a_q            <= a_d;
            b_q            <= b_d;
            a_row_q        <= a_row_d;
            b_col_q        <= b_col_d;
            clr_q          <= clr_d;
            enable_q       <= enable_d;
            update_ready_q <= update_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            start_ready_q  <= start_ready_d;
        end
    end

    assign a_row0       = a_row_q[0];
    assign a_row1       = a_row_q[1];
    assign a_row2       = a_row_q[2];
    assign a_row3       = a_row_q[3];
    assign b_col0       = b_col_q[0];
    assign b_col1       = b_col_q[1];
    assign b_col2       = b_col_q[2];
    assign b_col3       = b_col_q[3];
    assign clr          = clr_q;
    assign enable       = enable_q;
    assign update_ready = update_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign start_ready  = start_ready_q;

endmodule

// File: tb/tb_macarray_feeder.sv
// Directed + randomized bench for macarray_feeder; expected traces come from matrix-level
// skew rules evaluated per cycle relative to the accept edge.
module tb_macarray_feeder;

    typedef logic [38:0] ovec_t;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        start_valid;
    logic        start_ready;
    logic        mode_3x3;
    logic [63:0] a_mat;
    logic [63:0] b_mat;
    logic        abort;
    logic [3:0]  a_row0, a_row1, a_row2, a_row3;
    logic [3:0]  b_col0, b_col1, b_col2, b_col3;
    logic        clr;
    logic [1:0]  enable;
    logic        update_ready;
    logic        busy;
    logic        done;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    int cur_a[4][4];
    int cur_b[4][4];
    int nxt_a[4][4];
    int nxt_b[4][4];
    bit cur_mode;
    bit nxt_mode;

    localparam ovec_t IDLE_V  = {1'b1, 38'd0};
    localparam ovec_t RESET_V = 39'd0;

    ovec_t obs;
    assign obs = {start_ready, busy, done, update_ready, clr, enable,
                  a_row0, a_row1, a_row2, a_row3, b_col0, b_col1, b_col2, b_col3};

    always #5 CLK = ~CLK;

    macarray_feeder #(.DRAIN_CYCLES(4)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .mode_3x3     (mode_3x3),
        .a_mat        (a_mat),
        .b_mat        (b_mat),
        .abort        (abort),
        .a_row0       (a_row0),
        .a_row1       (a_row1),
        .a_row2       (a_row2),
        .a_row3       (a_row3),
        .b_col0       (b_col0),
        .b_col1       (b_col1),
        .b_col2       (b_col2),
        .b_col3       (b_col3),
        .clr          (clr),
        .enable       (enable),
        .update_ready (update_ready),
        .busy         (busy),
        .done         (done)
    );

    // Expected outputs c cycles after the accept edge (c = L+8 is the first idle cycle)
    function automatic ovec_t exp_vec(int c);
        int         l = cur_mode ? 5 : 7;
        int         k = cur_mode ? 3 : 4;
        int         t = c - 2;
        logic [3:0] ar[4];
        logic [3:0] bc[4];
        logic [1:0] en;
        logic       sr, bz, dn, ur, cl;
        for (int i = 0; i < 4; i++) begin
            ar[i] = 4'd0;
            bc[i] = 4'd0;
            if (t >= 0 && t < l && !(cur_mode && i == 3) && (t - i) >= 0 && (t - i) < k) begin
                ar[i] = 4'(cur_a[i][t - i]);
                bc[i] = 4'(cur_b[t - i][i]);
            end
        end
        sr = (c == l + 8);
        bz = (c >= 1 && c <= l + 7);
        dn = (c == l + 7);
        ur = (c == l + 6);
        cl = (c == 1);
        en = (c >= 1 && c <= l + 6) ? (cur_mode ? 2'b01 : 2'b11) : 2'b00;
        return {sr, bz, dn, ur, cl, en, ar[0], ar[1], ar[2], ar[3], bc[0], bc[1], bc[2], bc[3]};
    endfunction

    task automatic check(input string tag, input ovec_t expv, input int c);
        assert_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s c=%0d: observed %h expected %h", tag, c, obs, expv);
        end
    endtask

    task automatic drive_mats(input bit m, input int ma[4][4], input int mb[4][4]);
        mode_3x3 = m;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                a_mat[(4*i + k)*4 +: 4] = 4'(ma[i][k]);
                b_mat[(4*i + k)*4 +: 4] = 4'(mb[i][k]);
            end
        end
    endtask

    task automatic rand_next(input bit m);
        nxt_mode = m;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                nxt_a[i][k] = int'($urandom_range(15)) - 8;
                nxt_b[i][k] = int'($urandom_range(15)) - 8;
            end
        end
    endtask

    task automatic promote();
        cur_a    = nxt_a;
        cur_b    = nxt_b;
        cur_mode = nxt_mode;
    endtask

    // Caller has cur job on inputs, start_valid=1 and start_ready observed high
    task automatic run_job(input string tag, input int abort_at, input int rst_at, input bit chain);
        int l = cur_mode ? 5 : 7;
        for (int c = 1; c <= l + 8; c++) begin
            @(negedge CLK);
            check(tag, exp_vec(c), c);
            if (c == 1) begin
                abort = 1'b0;
                if (chain) drive_mats(nxt_mode, nxt_a, nxt_b);
                else start_valid = 1'b0;
            end
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge CLK);
                check({tag, "_abort"}, IDLE_V, c + 1);
                abort = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    @(negedge CLK);
                    check({tag, "_post_abort"}, IDLE_V, c + 2 + j);
                end
                return;
            end
            if (c == rst_at) begin
                RSTN = 1'b0;
                @(negedge CLK);
                check({tag, "_rst"}, RESET_V, c + 1);
                RSTN = 1'b1;
                for (int j = 0; j < 10; j++) begin
                    @(negedge CLK);
                    check({tag, "_post_rst"}, IDLE_V, c + 2 + j);
                end
                return;
            end
        end
    endtask

    task automatic start_cur();
        drive_mats(cur_mode, cur_a, cur_b);
        start_valid = 1'b1;
    endtask

    initial begin
        RSTN        = 1'b0;
        start_valid = 1'b0;
        abort       = 1'b0;
        mode_3x3    = 1'b0;
        a_mat       = 64'd0;
        b_mat       = 64'd0;

        repeat (2) @(negedge CLK);
        check("reset", RESET_V, 0);
        RSTN = 1'b1;
        @(negedge CLK);
        check("post_reset_idle", IDLE_V, 0);

        abort = 1'b1;
        @(negedge CLK);
        check("abort_in_idle", IDLE_V, 0);
        abort = 1'b0;

        // 4x4 ramp A against identity B
        cur_mode = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                cur_a[i][k] = i*4 + k - 8;
                cur_b[i][k] = (i == k) ? 1 : 0;
            end
        start_cur();
        run_job("job4x4_ramp", 0, 0, 1'b0);

        // 3x3 all ones
        cur_mode = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                cur_a[i][k] = 1;
                cur_b[i][k] = 1;
            end
        start_cur();
        run_job("job3x3_ones", 0, 0, 1'b0);

        // Abort at FEED t=3
        rand_next(1'b0);
        promote();
        start_cur();
        run_job("abort_feed", 5, 0, 1'b0);

        // Abort together with accept: accept wins
        rand_next(1'b0);
        promote();
        start_cur();
        abort = 1'b1;
        run_job("abort_at_accept", 0, 0, 1'b0);

        // Held start_valid with new matrices, back-to-back jobs
        rand_next(1'b0);
        promote();
        rand_next(1'b1);
        start_cur();
        run_job("b2b_first", 0, 0, 1'b1);
        promote();
        rand_next(1'b0);
        run_job("b2b_second", 0, 0, 1'b1);
        promote();
        run_job("b2b_third", 0, 0, 1'b0);

        // Reset mid-job
        rand_next(1'b0);
        promote();
        start_cur();
        run_job("rst_mid", 0, 4, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rand_next(1'($urandom_range(1)));
            promote();
            start_cur();
            run_job("random_job", 0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
